// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master -- single-transaction I2C master (one address byte, one data byte)
//
// A transaction is START, address byte {ADDR, RW}, address ACK slot, one data
// byte (written from WDATA or read into RDATA), data ACK slot, STOP.  Each bit
// is split into four quarters of CLKDIV clocks.  A quarter in which SCL is
// released is stretched for as long as a responder holds SCL low.
//
// Ports
//   CLCK       system clock, rising edge
//   RSTN       synchronous active-low reset
//   START      request; accepted only in IDLE, and not in the DONE cycle
//   RW         0 = write, 1 = read (latched on acceptance)
//   ADDR[6:0]  responder address (latched on acceptance)
//   WDATA[7:0] byte to write (latched on acceptance)
//   RDATA[7:0] last byte read
//   BUSY       transaction in progress
//   DONE       one-cycle completion pulse
//   ACKERR     NACK seen in the last transaction, held until next acceptance
//   SCL, SDA   open-drain bus lines, driven 0 or z only
//   dbg_state  current FSM state
//
// Handshake: START is a level sampled each cycle; when it is seen in IDLE
// (outside the DONE cycle) the request is taken that cycle and BUSY is high
// from the next cycle until DONE pulses, during which START is ignored.
// ---------------------------------------------------------------------------
module i2c_master #(
   parameter int CLKDIV = 250
) (
   input  logic       CLCK,
   input  logic       RSTN,
   input  logic       START,
   input  logic       RW,
   input  logic [6:0] ADDR,
   input  logic [7:0] WDATA,
   output logic [7:0] RDATA,
   output logic       BUSY,
   output logic       DONE,
   output logic       ACKERR,
   inout  wire        SCL,
   inout  wire        SDA,
   output logic [2:0] dbg_state
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_STRT = 3'd1,
      S_ADDR = 3'd2,
      S_AACK = 3'd3,
      S_DATA = 3'd4,
      S_DACK = 3'd5,
      S_STOP = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic          rw_q, rw_d;
   logic [6:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ackerr_q, ackerr_d;
   logic          done_q, done_d;
   logic          scl_low_q, scl_low_d;
   logic          sda_low_q, sda_low_d;

   logic scl_in, sda_in;
   logic hold, tick;

   assign scl_in = SCL;
   assign sda_in = SDA;

   assign SCL = scl_low_q ? 1'b0 : 1'bz;
   assign SDA = sda_low_q ? 1'b0 : 1'bz;

   // Line drive for a given position in the transaction: {scl_low, sda_low}.
   // Evaluated on the next-state values so the registered drives line up with
   // the quarter they belong to.
   function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qtr,
                                            input logic [2:0] bidx, input logic rw,
                                            input logic [6:0] addr, input logic [7:0] wdata);
      logic       scl_low;
      logic       sda_low;
      logic [7:0] abyte;
      abyte   = {addr, rw};
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (st)
         S_STRT: begin
            scl_low = (qtr >= 2'd2);
            sda_low = (qtr != 2'd0);
         end
         S_ADDR: begin
            scl_low = (qtr == 2'd0) || (qtr == 2'd3);
            sda_low = ~abyte[bidx];
         end
         S_DATA: begin
            scl_low = (qtr == 2'd0) || (qtr == 2'd3);
            sda_low = rw ? 1'b0 : ~wdata[bidx];
         end
         S_AACK, S_DACK: begin
            // SDA released: responder ACK, or master NACK on a read
            scl_low = (qtr == 2'd0) || (qtr == 2'd3);
         end
         S_STOP: begin
            scl_low = (qtr == 2'd0);
            sda_low = (qtr <= 2'd1);
         end
         default: begin
            scl_low = 1'b0;
            sda_low = 1'b0;
         end
      endcase
      return {scl_low, sda_low};
   endfunction

   always_comb begin
      state_d  = state_q;
      qtr_d    = qtr_q;
      div_d    = div_q;
      bit_d    = bit_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      shift_d  = shift_q;
      rdata_d  = rdata_q;
      ackerr_d = ackerr_q;
      done_d   = 1'b0;
      tick     = 1'b0;
      // A released SCL that still reads low is a responder stretching the clock.
      hold     = !scl_low_q && !scl_in;

      if (state_q == S_IDLE) begin
         if (START && !done_q) begin
            state_d  = S_STRT;
            qtr_d    = 2'd0;
            div_d    = '0;
            bit_d    = 3'd7;
            rw_d     = RW;
            addr_d   = ADDR;
            wdata_d  = WDATA;
            ackerr_d = 1'b0;
         end
      end else if (!hold) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            tick  = 1'b1;
         end else begin
            div_d = div_q + DW'(1);
         end
      end

      if (tick) begin
         qtr_d = qtr_q + 2'd1;
         // End of q2: SCL has been high for a full quarter, SDA is sampled.
         if (qtr_q == 2'd2) begin
            case (state_q)
               S_AACK: if (sda_in) ackerr_d = 1'b1;
               S_DATA: shift_d = {shift_q[6:0], sda_in};
               S_DACK: begin
                  if (!rw_q && sda_in) ackerr_d = 1'b1;
                  if (rw_q) rdata_d = shift_q;
               end
               default: ;
            endcase
         end
         if (qtr_q == 2'd3) begin
            case (state_q)
               S_STRT: begin
                  state_d = S_ADDR;
                  bit_d   = 3'd7;
               end
               S_ADDR: begin
                  if (bit_q == 3'd0) state_d = S_AACK;
                  else               bit_d   = bit_q - 3'd1;
               end
               S_AACK: begin
                  if (ackerr_q) begin
                     state_d = S_STOP;
                  end else begin
                     state_d = S_DATA;
                     bit_d   = 3'd7;
                  end
               end
               S_DATA: begin
                  if (bit_q == 3'd0) state_d = S_DACK;
                  else               bit_d   = bit_q - 3'd1;
               end
               S_DACK: state_d = S_STOP;
               S_STOP: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end

      {scl_low_d, sda_low_d} = bus_drive(state_d, qtr_d, bit_d, rw_d, addr_d, wdata_d);
   end

   always_ff @(posedge CLCK) begin
      if (!RSTN) begin
         state_q   <= S_IDLE;
         qtr_q     <= 2'd0;
         div_q     <= '0;
         bit_q     <= 3'd0;
         rw_q      <= 1'b0;
         addr_q    <= 7'd0;
         wdata_q   <= 8'd0;
         shift_q   <= 8'd0;
         rdata_q   <= 8'd0;
         ackerr_q  <= 1'b0;
         done_q    <= 1'b0;
         scl_low_q <= 1'b0;
         sda_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         shift_q   <= shift_d;
         rdata_q   <= rdata_d;
         ackerr_q  <= ackerr_d;
         done_q    <= done_d;
         scl_low_q <= scl_low_d;
         sda_low_q <= sda_low_d;
      end
   end

   assign RDATA     = rdata_q;
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;
   assign ACKERR    = ackerr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_master -- bench for i2c_master with a bit-level responder model.
// The responder watches the bus at each falling CLCK edge, decodes START /
// bits / STOP, answers ACKs, serves read data and can stretch one SCL low
// phase.  Expected results are pushed per request and checked when DONE
// pulses.
// ---------------------------------------------------------------------------
module tb_i2c_master;

   localparam int CLKDIV = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'd0;
   logic [7:0] wdata = 8'd0;
   logic [7:0] rdata;
   logic       busy, done, ackerr;
   logic [2:0] dbg_state;
   wire        scl_w, sda_w;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic slv_scl_low = 1'b0;
   logic slv_sda_low = 1'b0;

   pullup (scl_w);
   pullup (sda_w);
   assign scl_w = (slv_scl_low && rstn) ? 1'b0 : 1'bz;
   assign sda_w = (slv_sda_low && rstn) ? 1'b0 : 1'bz;

   i2c_master #(.CLKDIV(CLKDIV)) dut (
      .CLCK(clk), .RSTN(rstn), .START(start), .RW(rw), .ADDR(addr),
      .WDATA(wdata), .RDATA(rdata), .BUSY(busy), .DONE(done),
      .ACKERR(ackerr), .SCL(scl_w), .SDA(sda_w), .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- responder model ----------------
   logic [7:0] s_data = 8'h00;
   logic       s_aack = 1'b1;
   logic       s_dack = 1'b1;
   int         s_k = 0;
   int         s_s = 0;

   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic       in_xfer = 1'b0;
   int         bitcnt = 0;
   int         hold_cnt = 0;
   logic [7:0] sh_addr = 8'd0, sh_data = 8'd0;
   logic       dack_smp = 1'b0;
   logic       obs_valid = 1'b0;
   logic [7:0] obs_addr = 8'd0, obs_data = 8'd0;
   logic       obs_dack = 1'b0;
   int         obs_clocks = 0;
   logic       glitch = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         in_xfer     = 1'b0;
         slv_scl_low = 1'b0;
         slv_sda_low = 1'b0;
         bitcnt      = 0;
         hold_cnt    = 0;
         prev_scl    = 1'b1;
         prev_sda    = 1'b1;
      end else begin
         if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) slv_scl_low = 1'b0;
         end
         if (prev_scl && scl_w && prev_sda && !sda_w) begin
            if (in_xfer) glitch = 1'b1;
            in_xfer = 1'b1;
            bitcnt  = 0;
            sh_addr = 8'd0;
            sh_data = 8'd0;
         end else if (in_xfer && prev_scl && scl_w && !prev_sda && sda_w) begin
            in_xfer    = 1'b0;
            obs_valid  = 1'b1;
            obs_addr   = sh_addr;
            obs_data   = sh_data;
            obs_dack   = dack_smp;
            obs_clocks = bitcnt - 1;  // the last rise only sets up the STOP
         end else if (in_xfer && !prev_scl && scl_w) begin
            bitcnt++;
            if (bitcnt <= 8) sh_addr = {sh_addr[6:0], sda_w};
            else if (bitcnt >= 10 && bitcnt <= 17) sh_data = {sh_data[6:0], sda_w};
            else if (bitcnt == 18) dack_smp = sda_w;
         end else if (in_xfer && prev_scl && !scl_w) begin
            slv_sda_low = 1'b0;
            if (bitcnt == 8) slv_sda_low = s_aack;
            else if (bitcnt >= 9 && bitcnt <= 16 && sh_addr[0] && s_aack) slv_sda_low = !s_data[16 - bitcnt];
            else if (bitcnt == 17 && !sh_addr[0]) slv_sda_low = s_dack;
            if (bitcnt == s_k && s_s > 0) begin
               // master releases SCL two quarters after this fall; hold s_s beyond that
               slv_scl_low = 1'b1;
               hold_cnt    = 2 * CLKDIV + s_s;
            end
         end
         prev_scl = scl_w;
         prev_sda = sda_w;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] acc;
      logic [31:0] lat;
      logic [7:0]  abyte;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        ackerr;
      logic [4:0]  clocks;
      logic        chk_wdata;
      logic        chk_nack;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       e;
   logic [7:0] model_rdata = 8'h00;
   logic       done_prev = 1'b0;

   always @(negedge clk) begin
      if (rstn) begin
         if (done_prev) check("done_pulse_width", done, 1'b0);
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: DONE at cycle %0d with nothing outstanding", cyc);
            end else begin
               e = exp_q.pop_front();
               check("done_latency", cyc - int'(e.acc), e.lat);
               check("busy_at_done", busy, 1'b0);
               check("ackerr", ackerr, e.ackerr);
               check("rdata", rdata, e.rdata);
               check("stop_seen", obs_valid, 1'b1);
               check("addr_byte", obs_addr, e.abyte);
               check("scl_clocks", obs_clocks, e.clocks);
               if (e.chk_wdata) check("wdata_on_bus", obs_data, e.wdata);
               if (e.chk_nack) check("master_nack", obs_dack, 1'b1);
               check("sda_glitch", glitch, 1'b0);
               obs_valid = 1'b0;
               glitch    = 1'b0;
            end
         end
      end
      done_prev = done && rstn;
   end

   // ---------------- driver ----------------
   task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] sd, input logic aack, input logic dack,
                        input int k, input int s, output int acc);
      s_data = sd;
      s_aack = aack;
      s_dack = dack;
      s_k    = k;
      s_s    = s;
      @(negedge clk);
      start = 1'b1;
      rw    = r;
      addr  = a;
      wdata = wd;
      acc   = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", busy, 1'b1);
   endtask

   task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                          input logic [7:0] sd, input logic aack, input logic dack,
                          input int k, input int s, input logic noise);
      exp_t x;
      int   acc;
      int   t;
      x.abyte     = {a, r};
      x.wdata     = wd;
      x.ackerr    = !aack || (!r && !dack);
      x.clocks    = aack ? 5'd18 : 5'd9;
      x.lat       = (aack ? 80 : 44) * CLKDIV + ((k > 0 && s > 0) ? s : 0);
      if (r && aack) model_rdata = sd;
      x.rdata     = model_rdata;
      x.chk_wdata = !r && aack;
      x.chk_nack  = r && aack;
      issue(r, a, wd, sd, aack, dack, k, s, acc);
      x.acc = acc;
      exp_q.push_back(x);
      t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
         if (noise && t < 40 && !done) begin
            start = 1'($urandom_range(0, 1));
            rw    = 1'($urandom_range(0, 1));
            addr  = 7'($urandom_range(0, 127));
            wdata = 8'($urandom_range(0, 255));
         end else begin
            start = 1'b0;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no DONE within %0d cycles", t);
         return;
      end
      // START raised in the DONE cycle must not start a new transaction
      start = 1'b1;
      rw    = 1'($urandom_range(0, 1));
      addr  = 7'($urandom_range(0, 127));
      @(negedge clk);
      start = 1'b0;
      check("start_at_done_ignored", busy, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
   endtask

   task automatic reset_mid_txn();
      int acc;
      int t;
      issue(1'b1, 7'h33, 8'h00, 8'h5A, 1'b1, 1'b1, 0, 0, acc);
      t = 0;
      while (cyc < acc + 99 && t < 500) begin
         @(negedge clk);
         t++;
         start = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      rstn  = 1'b0;
      @(negedge clk);
      check("rst_scl_released", scl_w, 1'b1);
      check("rst_sda_released", sda_w, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ackerr", ackerr, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      model_rdata = 8'h00;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      // any DONE now is flagged by the scoreboard as unexpected
      repeat (400) @(negedge clk);
   endtask

   initial begin
      int t;
      repeat (4) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ackerr", ackerr, 1'b0);
      check("reset_rdata", rdata, 8'h00);
      check("reset_scl", scl_w, 1'b1);
      check("reset_sda", sda_w, 1'b1);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // directed: write, read, address NACK, stretched write
      run_txn(1'b0, 7'h72, 8'hA5, 8'h00, 1'b1, 1'b1, 0, 0, 1'b0);
      run_txn(1'b1, 7'h72, 8'h00, 8'h3C, 1'b1, 1'b1, 0, 0, 1'b1);
      run_txn(1'b0, 7'h72, 8'hA5, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
      run_txn(1'b0, 7'h72, 8'hA5, 8'h00, 1'b1, 1'b1, 3, 10, 1'b1);
      // data NACK on a write
      run_txn(1'b0, 7'h15, 8'h0F, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         logic r, aa, da;
         int   k, s;
         r  = 1'($urandom_range(0, 1));
         aa = ($urandom_range(0, 4) != 0);
         da = ($urandom_range(0, 4) != 0);
         k  = 0;
         s  = 0;
         if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(1, 8);
            s = $urandom_range(1, 20);
         end
         run_txn(r, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), aa, da, k, s, 1'($urandom_range(0, 1)));
      end

      reset_mid_txn();
      run_txn(1'b1, 7'h44, 8'h00, 8'hC3, 1'b1, 1'b1, 0, 0, 1'b0);

      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d transactions never completed", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLKDIV, default 250, giving the quarter-SCL-period length in CLCK cycles; legal range 2..65535.
REQ-002 SHALL have port CLCK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port START  input  1  transaction request, sampled every CLCK.
REQ-005 SHALL have port RW  input  1  transaction direction: 0 = write, 1 = read.
REQ-006 SHALL have port ADDR  input  7  target responder address.
REQ-007 SHALL have port WDATA  input  8  byte to write.
REQ-008 SHALL have port RDATA  output  8  last byte read.
REQ-009 SHALL have port BUSY  output  1  high while a transaction is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ACKERR  output  1  NACK seen in the last transaction; valid while DONE is high and held until the next acceptance.
REQ-012 SHALL have port SCL  inout  1  open-drain bus clock; drives 0 or z only.
REQ-013 SHALL have port SDA  inout  1  open-drain bus data; drives 0 or z only.

Function
REQ-014 SHALL accept START only in IDLE, latching RW/ADDR/WDATA that cycle (cycle 0) and raising BUSY in cycle 1; START while BUSY SHALL be ignored.
REQ-015 SHALL advance a quarter-phase counter (q0..q3) once every CLKDIV cycles while BUSY; the divider SHALL be width clog2(CLKDIV) and wrap to 0.
REQ-016 SHALL implement states IDLE -> STRT -> ADDR(8 bits: ADDR[6:0] MSB first, then RW) -> AACK -> DATA(8 bits) -> DACK -> STOP -> IDLE, each state/bit lasting 4 quarters.
REQ-017 STRT SHALL behave as follows: q0 both lines released; q1 SDA low with SCL high; q2-q3 SCL low.
REQ-018 Each bit SHALL behave as follows: q0 SCL low with SDA set to the bit; q1 SCL released; q2 SDA sampled with SCL high; q3 SCL low; SDA SHALL never change while SCL is high except in STRT/STOP.
REQ-019 Clock stretching: when SCL is released, the divider SHALL hold until SCL reads 1, extending the quarter by the stretch duration.
REQ-020 AACK SHALL release SDA; a sampled 1 SHALL set ACKERR and branch to STOP, skipping DATA/DACK.
REQ-021 A write SHALL drive WDATA MSB first in DATA; in DACK a sampled 1 SHALL set ACKERR.
REQ-022 A read SHALL release SDA in DATA and shift the samples into RDATA, MSB first; in DACK the master SHALL release SDA (NACK); RDATA SHALL update in the last DACK quarter.
REQ-023 STOP SHALL behave as follows: q0 SCL low with SDA low; q1 SCL released; q2 SDA released with SCL high; q3 idle high.
REQ-024 Without stretching, DONE SHALL pulse in cycle 80*CLKDIV (full transaction) or 44*CLKDIV (address NACK), with BUSY falling that same cycle.
REQ-025 The master SHALL generate exactly 18 SCL rising edges for a full transaction and 9 for an address NACK.
REQ-026 START asserted in the same cycle DONE pulses SHALL be ignored; START is accepted from the next cycle.

Reset
REQ-027 While RSTN=0 at a CLCK edge: FSM to IDLE, SCL=z, SDA=z, BUSY=0, DONE=0, ACKERR=0, RDATA=8'h00, counters cleared.
REQ-028 Reset mid-transaction SHALL release both lines immediately, with no STOP generated and no DONE.

Verification
REQ-029 CLKDIV=4, write ADDR=7'h72, WDATA=8'hA5, responder ACKs -> SDA bits 0xE4 then 0xA5, DONE in cycle 320, ACKERR=0.
REQ-030 CLKDIV=4, read ADDR=7'h72, responder drives 8'h3C -> RDATA=8'h3C, SDA high at the 9th data clock, ACKERR=0, DONE in cycle 320.
REQ-031 Address NACK (SDA left high) -> ACKERR=1, 9 SCL rising edges, DONE in cycle 176.
REQ-032 Responder holds SCL low 10 cycles during bit 3 -> DONE in cycle 330, data unchanged.
REQ-033 START pulses while BUSY, and RSTN=0 at cycle 100 -> START ignored; on reset SCL/SDA become z next edge, BUSY=0, no DONE.
